montgomery_mul: RTL and testbench

Radix-2 bit-serial Montgomery modular multiplier computing result = in_a · in_b · 2^(−512) mod in_m. It is the direct upstream user of the multi-cycle `adder` stage: every addition, and the final conditional subtraction, is issued to one instance of `adder` through its start/done handshake. It sits between the RSA exponentiation control and the arithmetic datapath.

---
 rtl/ddp_pkg.sv | 18 +
 rtl/montgomery_mul_if.sv | 15 +
 rtl/adder.sv | 57 +++++
 rtl/montgomery_mul.sv | 128 ++++++++++++
 tb/tb_montgomery_mul.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ddp_pkg.sv
// Shared datapath definitions for the Montgomery multiplier and its adder stage.
package ddp_pkg;
  localparam int N       = 512;
  localparam int ADDER_W = 514;
  localparam int CNT_W   = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHK_A,
    S_WAIT_B,
    S_CHK_C,
    S_WAIT_M,
    S_SHIFT,
    S_SUB,
    S_WAIT_S,
    S_DONE
  } state_e;
endpackage

// File: rtl/montgomery_mul_if.sv
// Operand/result bus of the Montgomery multiplier; master drives operands and start.
interface montgomery_mul_if;
  import ddp_pkg::*;

  // start is a one-cycle request accepted only when idle; done pulses once when result is valid.
  logic         start;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic [N-1:0] result;
  logic         done;

  modport master (output start, in_a, in_b, in_m, input result, done);
  modport slave  (input start, in_a, in_b, in_m, output result, done);
endinterface

// File: rtl/adder.sv
// Two-cycle 514-bit add/subtract unit: operands latched on start, result and done one cycle later.
module adder
  import ddp_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               subtract,
  input  logic [ADDER_W-1:0] in_a,
  input  logic [ADDER_W-1:0] in_b,
  output logic [ADDER_W:0]   result,
  output logic               done
);
  logic [ADDER_W-1:0] a_q, a_d, b_q, b_d;
  logic               sub_q, sub_d, busy_q, busy_d, done_q, done_d;
  logic [ADDER_W:0]   result_q, result_d;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    if (start) begin
      a_d    = in_a;
      b_d    = in_b;
      sub_d  = subtract;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Top bit of a subtraction is the borrow (set when in_a < in_b).
      result_d = sub_q ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
endmodule

// File: rtl/montgomery_mul.sv
// Radix-2 bit-serial Montgomery multiplier: result = a * b * 2^-512 mod m, all additions via u_adder.
module montgomery_mul
  import ddp_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  montgomery_mul_if.slave         bus,
  output state_e                  dbg_state
);
  state_e             state_q, state_d;
  logic [N-1:0]       a_q, a_d, b_q, b_d, m_q, m_d, result_q, result_d;
  logic [ADDER_W-1:0] c_q, c_d;
  logic [CNT_W-1:0]   i_q, i_d;
  logic               add_start_q, add_start_d, add_sel_m_q, add_sel_m_d, add_sub_q, add_sub_d;
  logic [ADDER_W-1:0] add_in_b;
  logic [ADDER_W:0]   add_res;
  logic               add_done;

  // Select registers only change when a new adder op is launched, so operands stay stable until done.
  assign add_in_b = add_sel_m_q ? {2'b00, m_q} : {2'b00, b_q};

  adder u_adder (
    .clk      (clk),
    .resetn   (resetn),
    .start    (add_start_q),
    .subtract (add_sub_q),
    .in_a     (c_q),
    .in_b     (add_in_b),
    .result   (add_res),
    .done     (add_done)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    c_d         = c_q;
    i_d         = i_q;
    result_d    = result_q;
    add_start_d = 1'b0;
    add_sel_m_d = add_sel_m_q;
    add_sub_d   = add_sub_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        a_d     = bus.in_a;
        b_d     = bus.in_b;
        m_d     = bus.in_m;
        c_d     = '0;
        i_d     = '0;
        state_d = S_CHK_A;
      end
      S_CHK_A: if (a_q[0]) begin
        add_start_d = 1'b1;
        add_sel_m_d = 1'b0;
        add_sub_d   = 1'b0;
        state_d     = S_WAIT_B;
      end else begin
        state_d = S_CHK_C;
      end
      S_WAIT_B: if (add_done) begin
        c_d     = add_res[ADDER_W-1:0];
        state_d = S_CHK_C;
      end
      S_CHK_C: if (c_q[0]) begin
        add_start_d = 1'b1;
        add_sel_m_d = 1'b1;
        add_sub_d   = 1'b0;
        state_d     = S_WAIT_M;
      end else begin
        state_d = S_SHIFT;
      end
      S_WAIT_M: if (add_done) begin
        c_d     = add_res[ADDER_W-1:0];
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        c_d     = c_q >> 1;
        a_d     = a_q >> 1;
        i_d     = i_q + CNT_W'(1);
        state_d = (i_q == CNT_W'(N - 1)) ? S_SUB : S_CHK_A;
      end
      S_SUB: begin
        add_start_d = 1'b1;
        add_sel_m_d = 1'b1;
        add_sub_d   = 1'b1;
        state_d     = S_WAIT_S;
      end
      S_WAIT_S: if (add_done) begin
        // Borrow means C < M, so C is already fully reduced.
        result_d = add_res[ADDER_W] ? c_q[N-1:0] : add_res[N-1:0];
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      c_q         <= '0;
      i_q         <= '0;
      result_q    <= '0;
      add_start_q <= 1'b0;
      add_sel_m_q <= 1'b0;
      add_sub_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      c_q         <= c_d;
      i_q         <= i_d;
      result_q    <= result_d;
      add_start_q <= add_start_d;
      add_sel_m_q <= add_sel_m_d;
      add_sub_q   <= add_sub_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = (state_q == S_DONE);
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_montgomery_mul.sv
// Self-checking bench for montgomery_mul against a modular-arithmetic reference model.
module tb_montgomery_mul;
  import ddp_pkg::*;

  localparam int L      = 2;
  localparam int BUDGET = 6000;

  logic   clk = 1'b0;
  logic   resetn;
  state_e dbg_state;
  int     vectors = 0;
  int     miscompares = 0;
  int     done_count = 0;
  int     add_starts = 0;
  int     sub_starts = 0;

  montgomery_mul_if bus ();

  montgomery_mul dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done) done_count++;
    if (dut.u_adder.start) begin
      if (dut.u_adder.subtract) sub_starts++;
      else add_starts++;
    end
  end

  // Reference: (a*b mod m) followed by 512 modular halvings.
  function automatic logic [N-1:0] mont_ref(input logic [N-1:0] a, b, m);
    logic [1023:0] p;
    p = ({512'b0, a} * {512'b0, b}) % {512'b0, m};
    for (int k = 0; k < N; k++)
      p = p[0] ? ((p + {512'b0, m}) >> 1) : (p >> 1);
    return p[N-1:0];
  endfunction

  // Cycles from accepted start through the done cycle, from the iteration timing rules.
  function automatic int exp_cycles(input logic [N-1:0] a, b, m);
    logic [N+1:0] c;
    int cyc;
    c = '0;
    cyc = 0;
    for (int k = 0; k < N; k++) begin
      cyc += 3;
      if (a[k]) begin c = c + {2'b00, b}; cyc += L + 1; end
      if (c[0]) begin c = c + {2'b00, m}; cyc += L + 1; end
      c = c >> 1;
    end
    return 1 + cyc + 1 + L + 1 + 1;
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] r;
    for (int k = 0; k < N / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic start_op(input logic [N-1:0] a, b, m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in_a  = a;
    bus.in_b  = b;
    bus.in_m  = m;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle; cyc is the cycle index relative to the start cycle.
  task automatic wait_done(output int cyc, output bit timeout);
    cyc = 1;
    while (!bus.done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    timeout = !bus.done;
  endtask

  task automatic test_reset();
    int s0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    vectors++;
    if (bus.result !== '0) begin miscompares++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    vectors++;
    if (dbg_state !== S_IDLE) begin miscompares++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    s0 = add_starts + sub_starts;
    repeat (10) @(negedge clk);
    vectors++;
    if (add_starts + sub_starts !== s0) begin miscompares++; $display("FAIL idle_adder_start got=%0d exp=0", add_starts + sub_starts - s0); end
  endtask

  task automatic check_op(input string name, input logic [N-1:0] a, b, m, input bit chk_lat);
    int cyc, d0;
    bit to;
    logic [N-1:0] exp;
    exp = mont_ref(a, b, m);
    d0 = done_count;
    start_op(a, b, m);
    wait_done(cyc, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL %s_timeout no done within %0d cycles", name, BUDGET); end
    vectors++;
    if (bus.result !== exp) begin miscompares++; $display("FAIL %s_result got=%h exp=%h", name, bus.result, exp); end
    if (chk_lat) begin
      vectors++;
      if (cyc + 1 !== exp_cycles(a, b, m)) begin miscompares++; $display("FAIL %s_latency got=%0d exp=%0d", name, cyc + 1, exp_cycles(a, b, m)); end
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (done_count - d0 !== 1) begin miscompares++; $display("FAIL %s_done_pulses got=%0d exp=1", name, done_count - d0); end
  endtask

  task automatic test_small();
    check_op("small", 512'd5, 512'd7, 512'd11, 1'b1);
    vectors++;
    if (bus.result !== 512'd6) begin miscompares++; $display("FAIL small_const got=%0d exp=6", bus.result); end
  endtask

  task automatic test_corners();
    int a0, s0;
    check_op("one", 512'd1, 512'd1, 512'd3, 1'b1);
    vectors++;
    if (bus.result !== 512'd1) begin miscompares++; $display("FAIL one_const got=%0d exp=1", bus.result); end
    a0 = add_starts;
    s0 = sub_starts;
    check_op("zero", 512'd0, 512'd2, 512'd3, 1'b1);
    vectors++;
    if (bus.result !== 512'd0) begin miscompares++; $display("FAIL zero_const got=%0d exp=0", bus.result); end
    vectors++;
    if (add_starts - a0 !== 0) begin miscompares++; $display("FAIL zero_no_add got=%0d exp=0", add_starts - a0); end
    vectors++;
    if (sub_starts - s0 !== 1) begin miscompares++; $display("FAIL zero_one_sub got=%0d exp=1", sub_starts - s0); end
  endtask

  task automatic test_large();
    logic [N-1:0] m;
    m = '1;
    m = m - 512'd568;
    check_op("large", m - 512'd1, m - 512'd1, m, 1'b1);
  endtask

  task automatic test_random(input int n);
    logic [N-1:0] m, a, b;
    for (int k = 0; k < n; k++) begin
      m = rand_wide();
      m[0] = 1'b1;
      if (m < 512'd3) m = 512'd3;
      a = rand_wide() % m;
      b = rand_wide() % m;
      check_op($sformatf("rand%0d", k), a, b, m, 1'b1);
    end
  endtask

  task automatic test_ignore_start();
    logic [N-1:0] m, a, b, exp;
    int cyc, d0;
    bit to;
    m = rand_wide() | 512'd1;
    a = rand_wide() % m;
    b = rand_wide() % m;
    exp = mont_ref(a, b, m);
    d0 = done_count;
    start_op(a, b, m);
    repeat (8) @(negedge clk);
    start_op(b, a, m ^ 512'd2);
    wait_done(cyc, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL ignore_timeout no done within %0d cycles", BUDGET); end
    vectors++;
    if (bus.result !== exp) begin miscompares++; $display("FAIL ignore_result got=%h exp=%h", bus.result, exp); end
    repeat (20) @(negedge clk);
    vectors++;
    if (done_count - d0 !== 1) begin miscompares++; $display("FAIL ignore_done_pulses got=%0d exp=1", done_count - d0); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] m;
    int d0;
    m = rand_wide() | 512'd1;
    d0 = done_count;
    start_op(rand_wide() % m, rand_wide() % m, m);
    repeat (40) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    vectors++;
    if (done_count !== d0) begin miscompares++; $display("FAIL rst_mid_done got=%0d exp=0", done_count - d0); end
    vectors++;
    if (dbg_state !== S_IDLE) begin miscompares++; $display("FAIL rst_mid_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    vectors++;
    if (bus.result !== '0) begin miscompares++; $display("FAIL rst_mid_result got=%h exp=0", bus.result); end
    m = rand_wide() | 512'd1;
    check_op("rst_fresh", rand_wide() % m, rand_wide() % m, m, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] m, a, b, exp1, exp2;
    int cyc;
    bit to;
    m = rand_wide() | 512'd1;
    a = rand_wide() % m;
    b = rand_wide() % m;
    exp1 = mont_ref(a, b, m);
    exp2 = mont_ref(b, b, m);
    start_op(a, b, m);
    wait_done(cyc, to);
    vectors++;
    if (to || bus.result !== exp1) begin miscompares++; $display("FAIL b2b_first got=%h exp=%h timeout=%b", bus.result, exp1, to); end
    // Held start: ignored in the DONE cycle, accepted in the following IDLE cycle.
    bus.start = 1'b1;
    bus.in_a  = b;
    bus.in_b  = b;
    bus.in_m  = m;
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.result !== exp1) begin miscompares++; $display("FAIL b2b_hold done=%b got=%h exp=%h", bus.done, bus.result, exp1); end
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, to);
    vectors++;
    if (to || bus.result !== exp2) begin miscompares++; $display("FAIL b2b_second got=%h exp=%h timeout=%b", bus.result, exp2, to); end
    vectors++;
    if (cyc + 1 !== exp_cycles(b, b, m)) begin miscompares++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc + 1, exp_cycles(b, b, m)); end
    repeat (10) @(negedge clk);
    vectors++;
    if (bus.result !== exp2) begin miscompares++; $display("FAIL b2b_stable got=%h exp=%h", bus.result, exp2); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    bus.in_m  = '0;
    test_reset();
    test_small();
    test_corners();
    test_large();
    test_random(2);
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
